// File: rtl/decode_cycle.sv
// ID stage of the RV32IM pipeline: register file, control decode, immediate generation, ID/EX register.
// Optional RF_BYPASS_EN forwards a same-cycle WB write into the rs1/rs2 read path.
module decode_cycle #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallE,
  input  logic            FlushE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            is_jalr_E,
  output logic            ALUSrcAE,
  output logic            ALUSrcBE,
  output logic [4:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic            IllegalE
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_PASSB  = 5'd18
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            is_jalr;
    logic            alu_src_a;
    logic            alu_src_b;
    logic [4:0]      alu_ctrl;
    logic [2:0]      funct3;
    logic            illegal;
  } idex_t;

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  idex_t           idex_q, idex_d, dec;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            legal;
  logic            wb_wr;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];
  assign rd     = InstrD[11:7];

  assign imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
  assign imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign imm_u = {InstrD[31:12], 12'b0};
  assign imm_j = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

  assign wb_wr = RegWriteW && (RdW != 5'd0);

  // Register file: x0 entry is never written, and reads of x0 are forced to zero anyway.
  always_comb begin
    rf_d = rf_q;
    if (wb_wr) rf_d[RdW] = ResultW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef RF_BYPASS_EN
    if (wb_wr && (RdW == rs1)) rs1_val = ResultW;
    if (wb_wr && (RdW == rs2)) rs2_val = ResultW;
`else
`endif
  end

  always_comb begin
    dec          = '0;
    legal        = 1'b1;
    dec.rd1      = rs1_val;
    dec.rd2      = rs2_val;
    dec.pc       = PCD;
    dec.pc_plus4 = PCPlus4D;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.funct3   = funct3;
    case (opcode_e'(opcode))
      OPC_LUI: begin
        dec.imm       = imm_u;
        dec.alu_ctrl  = ALU_PASSB;
        dec.alu_src_b = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm       = imm_u;
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.imm        = imm_j;
        dec.alu_ctrl   = ALU_ADD;
        dec.alu_src_a  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.reg_write  = 1'b1;
      end
      OPC_JALR: begin
        dec.imm        = imm_i;
        dec.alu_ctrl   = ALU_ADD;
        dec.jump       = 1'b1;
        dec.is_jalr    = 1'b1;
        dec.result_src = 2'b10;
        dec.reg_write  = 1'b1;
        if (funct3 != 3'b000) legal = 1'b0;
      end
      OPC_BRANCH: begin
        dec.imm      = imm_b;
        dec.alu_ctrl = ALU_SUB;
        dec.branch   = 1'b1;
        if (funct3 == 3'b010 || funct3 == 3'b011) legal = 1'b0;
      end
      OPC_LOAD: begin
        dec.imm        = imm_i;
        dec.alu_ctrl   = ALU_ADD;
        dec.alu_src_b  = 1'b1;
        dec.result_src = 2'b01;
        dec.reg_write  = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) legal = 1'b0;
      end
      OPC_STORE: begin
        dec.imm       = imm_s;
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src_b = 1'b1;
        dec.mem_write = 1'b1;
        if (funct3[2] || funct3 == 3'b011) legal = 1'b0;
      end
      OPC_OPIMM: begin
        dec.imm       = imm_i;
        dec.alu_src_b = 1'b1;
        dec.reg_write = 1'b1;
        case (funct3)
          3'b000: dec.alu_ctrl = ALU_ADD;
          3'b001: begin
            dec.alu_ctrl = ALU_SLL;
            if (funct7 != 7'h00) legal = 1'b0;
          end
          3'b010: dec.alu_ctrl = ALU_SLT;
          3'b011: dec.alu_ctrl = ALU_SLTU;
          3'b100: dec.alu_ctrl = ALU_XOR;
          3'b101: begin
            if (funct7 == 7'h00)      dec.alu_ctrl = ALU_SRL;
            else if (funct7 == 7'h20) dec.alu_ctrl = ALU_SRA;
            else                      legal = 1'b0;
          end
          3'b110: dec.alu_ctrl = ALU_OR;
          default: dec.alu_ctrl = ALU_AND;
        endcase
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'h01) begin
          // M-extension codes are laid out contiguously in funct3 order.
          dec.alu_ctrl = ALU_MUL + {2'b00, funct3};
        end else if (funct7 == 7'h20) begin
          if (funct3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
          else if (funct3 == 3'b101) dec.alu_ctrl = ALU_SRA;
          else                       legal = 1'b0;
        end else if (funct7 == 7'h00) begin
          case (funct3)
            3'b000: dec.alu_ctrl = ALU_ADD;
            3'b001: dec.alu_ctrl = ALU_SLL;
            3'b010: dec.alu_ctrl = ALU_SLT;
            3'b011: dec.alu_ctrl = ALU_SLTU;
            3'b100: dec.alu_ctrl = ALU_XOR;
            3'b101: dec.alu_ctrl = ALU_SRL;
            3'b110: dec.alu_ctrl = ALU_OR;
            default: dec.alu_ctrl = ALU_AND;
          endcase
        end else begin
          legal = 1'b0;
        end
      end
      default: begin
        // The all-zero word is the IF/ID bubble: quiet, not a trap.
        legal = (InstrD == '0);
      end
    endcase
    if (!legal) begin
      dec.reg_write  = 1'b0;
      dec.mem_write  = 1'b0;
      dec.branch     = 1'b0;
      dec.jump       = 1'b0;
      dec.is_jalr    = 1'b0;
      dec.result_src = 2'b00;
      dec.illegal    = 1'b1;
    end
  end

  always_comb begin
    if (FlushE)      idex_d = '0;
    else if (StallE) idex_d = idex_q;
    else             idex_d = dec;
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign RegWriteE   = idex_q.reg_write;
  assign ResultSrcE  = idex_q.result_src;
  assign MemWriteE   = idex_q.mem_write;
  assign BranchE     = idex_q.branch;
  assign JumpE       = idex_q.jump;
  assign is_jalr_E   = idex_q.is_jalr;
  assign ALUSrcAE    = idex_q.alu_src_a;
  assign ALUSrcBE    = idex_q.alu_src_b;
  assign ALUControlE = idex_q.alu_ctrl;
  assign Funct3E     = idex_q.funct3;
  assign IllegalE    = idex_q.illegal;

endmodule
